// File: rtl/leaf_latency_reporter_pkg.sv
// Shared message parameters for leaf-to-hub result messages.
// Holds header field positions, header codes, FSM state encodings and
// a helper that packs a per-leaf result message.
package leaf_latency_reporter_pkg;

  localparam int MSG_HEADER_MSB = 63;
  localparam int MSG_HEADER_LSB = 56;
  localparam int LAT_W          = 16;

  localparam logic [7:0] HEADER_RESULT = 8'h03;

  // FSM state encodings (kept as plain constants for legacy tools)
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_COUNTING = 2'd1;
  localparam logic [1:0] ST_SEND     = 2'd2;

  // Per-leaf result: bit 55 (overall flag) stays 0, unused bits stay 0.
  function automatic logic [63:0] build_result_msg(
    input logic [7:0]       round_cnt,
    input logic [2:0]       leaf_id,
    input logic [LAT_W-1:0] latency
  );
    logic [63:0] msg;
    msg = '0;
    msg[MSG_HEADER_MSB:MSG_HEADER_LSB] = HEADER_RESULT;
    msg[31:24] = round_cnt;
    msg[18:16] = leaf_id;
    msg[15:0]  = latency;
    return msg;
  endfunction

endpackage

// File: rtl/leaf_latency_reporter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: count updates one cycle after clr/inc; count_plus1 is combinational.
// Backpressure: none; inc simply holds at all-ones once saturated.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count_plus1
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next value after one more increment, held at all-ones instead of wrapping.
  assign count_plus1 = (&count_q) ? count_q : count_q + 1'b1;

  // Clear has priority so a new round always starts from zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_plus1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/leaf_latency_reporter.sv
// Measures start-to-done latency of a decode round and sends one result message uplink.
// Latency: tx_valid rises the cycle after done; message held until tx_ready handshake.
// Backpressure: tx_valid/tx_data hold while tx_ready low; optional stats via LATENCY_REPORTER_STATS_EN.
module leaf_latency_reporter
  import leaf_latency_reporter_pkg::*;
#(
  parameter logic [2:0] FPGA_ID       = 3'd0,
  parameter int         CHANNEL_WIDTH = 64   // only 64 is supported
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     done,
  output logic [CHANNEL_WIDTH-1:0] tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic [7:0]               round_count
`ifdef LATENCY_REPORTER_STATS_EN
  ,
  output logic [LAT_W-1:0]         max_latency,
  output logic                     saturated
`endif
);

  logic [1:0]       state_q,   state_d;
  logic             pend_q,    pend_d;
  logic             valid_q,   valid_d;
  logic [63:0]      data_q,    data_d;
  logic [7:0]       rc_q,      rc_d;
  logic             cnt_clr;
  logic             cnt_inc;
  logic [LAT_W-1:0] lat_next;
  logic             hs;

  sat_counter #(.WIDTH(LAT_W)) u_lat_cnt (
    .clk         (clk),
    .reset       (reset),
    .clr         (cnt_clr),
    .inc         (cnt_inc),
    .count_plus1 (lat_next)
  );

  // Handshake uses only registered valid, so tx_valid never depends on tx_ready.
  assign hs          = valid_q & tx_ready;
  assign tx_valid    = valid_q;
  assign tx_data     = data_q;
  assign busy        = (state_q != ST_IDLE);
  assign round_count = rc_q;

  // Round sequencing: count, latch message on done, hold until accepted.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    data_d  = data_q;
    rc_d    = rc_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // done in IDLE is ignored, even alongside start
        if (start) begin
          state_d = ST_COUNTING;
          cnt_clr = 1'b1;
        end
      end
      ST_COUNTING: begin
        // start in COUNTING is dropped; done wins if both arrive
        cnt_inc = 1'b1;
        if (done) begin
          state_d = ST_SEND;
          valid_d = 1'b1;
          data_d  = build_result_msg(rc_q, FPGA_ID, lat_next);
        end
      end
      ST_SEND: begin
        if (start) begin
          pend_d = 1'b1;
        end
        if (hs) begin
          valid_d = 1'b0;
          rc_d    = rc_q + 8'd1;
          pend_d  = 1'b0;
          // A start seen during SEND (including this cycle) begins the next round here
          if (pend_q || start) begin
            state_d = ST_COUNTING;
            cnt_clr = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and message registers; reset aborts any round in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      rc_q    <= rc_d;
    end
  end

`ifdef LATENCY_REPORTER_STATS_EN
  logic [LAT_W-1:0] max_q, max_d;
  logic             sat_q, sat_d;

  // Statistics follow only messages actually accepted downstream.
  always_comb begin
    max_d = max_q;
    sat_d = sat_q;
    if (hs) begin
      if (data_q[15:0] > max_q) begin
        max_d = data_q[15:0];
      end
      if (&data_q[15:0]) begin
        sat_d = 1'b1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      max_q <= '0;
      sat_q <= 1'b0;
    end else begin
      max_q <= max_d;
      sat_q <= sat_d;
    end
  end

  assign max_latency = max_q;
  assign saturated   = sat_q;
`endif

endmodule
